alu_issue_ctrl: RTL and testbench

- Sequencer for the ALU datapath: accepts 32-bit instruction words via valid/ready, decodes them to ALU controls (Imm, S, Cin), and drives them through a 3-stage ID -> EX -> WB control pipeline.
- Detects read-after-write register hazards and stalls issue; the datapath has no forwarding.
- Sits between the instruction source and the register file/ALU.

---
 rtl/alu_issue_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Issue sequencer for the ALU datapath. It accepts 32-bit instruction words
//   over a valid/ready handshake and decodes them into ALU controls (Imm, S,
//   Cin). The controls then move through a 3-stage ID -> EX -> WB pipeline.
//   The datapath has no forwarding. A read-after-write dependency on an
//   instruction still in EX or WB therefore holds the consumer in ID, and
//   bubbles are inserted into EX until the producer has written back.
//
//   Optional feature macro: ALU_ISSUE_PERF_EN
//     When defined, the block adds the saturating counters retire_cnt and
//     stall_cnt.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   ibus/ivalid     instruction word and offer strobe
//   iready          ID can take ibus this cycle
//   ex_valid        EX holds a real instruction
//   imm_ex/s_ex/cin_ex   ALU B-select, function, carry-in
//   rs_ex/rt_ex     register-file read addresses
//   imm16_ex        immediate field
//   wb_valid/wb_rd  register-file write strobe and destination
//   illegal         one-cycle pulse after an undecodable word is accepted
//   retire_cnt/stall_cnt  (ALU_ISSUE_PERF_EN only) performance counters
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ibus,
  input  logic              ivalid,
  output logic              iready,
  output logic              ex_valid,
  output logic              imm_ex,
  output logic [2:0]        s_ex,
  output logic              cin_ex,
  output logic [ADDR_W-1:0] rs_ex,
  output logic [ADDR_W-1:0] rt_ex,
  output logic [15:0]       imm16_ex,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_rd,
  output logic              illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  // Register fields are 5 bits wide in the instruction word. A narrower
  // address bus would silently alias registers, so it is rejected here.
  if (ADDR_W < 5 || CNT_W < 1) begin : g_bad_cfg
    $error("alu_issue_ctrl: ADDR_W must be >= 5 and CNT_W >= 1");
  end

  typedef struct packed {
    logic       legal;
    logic       imm;     // 1 = immediate B operand (I-type)
    logic [2:0] s;
    logic       cin;
    logic       use_rt;  // rt is a source operand (R-type only)
    logic [4:0] dest;
  } dec_t;

  // Undecodable words come back all-zero. The bubble and no-hazard
  // behaviour of illegal words then follows from legal=0 alone.
  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    if (w[31:26] == 6'b000000) begin
      d.imm    = 1'b0;
      d.use_rt = 1'b1;
      d.dest   = w[15:11];
      case (w[5:0])
        6'b000011: begin d.s = 3'b010; d.cin = 1'b0; end  // ADD
        6'b000010: begin d.s = 3'b011; d.cin = 1'b1; end  // SUB
        6'b000001: begin d.s = 3'b000; d.cin = 1'b0; end  // XOR
        6'b000111: begin d.s = 3'b110; d.cin = 1'b0; end  // AND
        6'b000100: begin d.s = 3'b100; d.cin = 1'b0; end  // OR
        default:   d.legal = 1'b0;
      endcase
    end else begin
      d.imm    = 1'b1;
      d.use_rt = 1'b0;
      d.dest   = w[20:16];
      case (w[31:26])
        6'b000011: begin d.s = 3'b010; d.cin = 1'b0; end  // ADDI
        6'b000010: begin d.s = 3'b011; d.cin = 1'b1; end  // SUBI
        6'b000001: begin d.s = 3'b000; d.cin = 1'b0; end  // XORI
        6'b001111: begin d.s = 3'b110; d.cin = 1'b0; end  // ANDI
        6'b001100: begin d.s = 3'b100; d.cin = 1'b0; end  // ORI
        default:   d.legal = 1'b0;
      endcase
    end
    if (!d.legal) d = '0;
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic              id_valid;
  logic [31:0]       id_word;
  logic [ADDR_W-1:0] ex_dest;

  dec_t              id_dec;
  dec_t              in_dec;
  logic [ADDR_W-1:0] src_a, src_b;
  logic              hit_a, hit_b;
  logic              hazard;
  logic              accept;
  logic              issue;

  assign id_dec = decode(id_word);
  assign in_dec = decode(ibus);

  assign src_a = ADDR_W'(id_word[25:21]);
  assign src_b = ADDR_W'(id_word[20:16]);

  // Register 0 is never a real dependency, so it is excluded as a source.
  always_comb begin
    hit_a = (src_a != '0) &&
            ((ex_valid && (src_a == ex_dest)) || (wb_valid && (src_a == wb_rd)));
    hit_b = id_dec.use_rt && (src_b != '0) &&
            ((ex_valid && (src_b == ex_dest)) || (wb_valid && (src_b == wb_rd)));
    hazard = id_valid && id_dec.legal && (hit_a || hit_b);
  end

  // hazard already implies id_valid, so this is !id_valid || !hazard.
  assign iready = !hazard;
  assign accept = ivalid && iready;
  assign issue  = id_valid && id_dec.legal && !hazard;

  // ID: holds its word while stalled and otherwise loads on every edge. With
  // ivalid low it loads a bubble. The stale word is harmless because id_valid
  // is then 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_word  <= '0;
    end else if (!hazard) begin
      id_valid <= ivalid;
      if (ivalid) id_word <= ibus;
    end
  end

  // illegal is registered at the accepting edge, so it is seen in the cycle
  // the word sits in ID. Illegal words never stall, so the pulse is one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal <= 1'b0;
    else        illegal <= accept && !in_dec.legal;
  end

  // EX: every control is forced to zero on a bubble. A downstream observer
  // then sees no activity on the ALU controls while ex_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      imm_ex   <= 1'b0;
      s_ex     <= '0;
      cin_ex   <= 1'b0;
      rs_ex    <= '0;
      rt_ex    <= '0;
      imm16_ex <= '0;
      ex_dest  <= '0;
    end else if (issue) begin
      ex_valid <= 1'b1;
      imm_ex   <= id_dec.imm;
      s_ex     <= id_dec.s;
      cin_ex   <= id_dec.cin;
      rs_ex    <= src_a;
      rt_ex    <= src_b;
      imm16_ex <= id_word[15:0];
      ex_dest  <= ADDR_W'(id_dec.dest);
    end else begin
      ex_valid <= 1'b0;
      imm_ex   <= 1'b0;
      s_ex     <= '0;
      cin_ex   <= 1'b0;
      rs_ex    <= '0;
      rt_ex    <= '0;
      imm16_ex <= '0;
      ex_dest  <= '0;
    end
  end

  // WB: always advances, including during an ID stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
    end else begin
      wb_valid <= ex_valid;
      wb_rd    <= ex_valid ? ex_dest : '0;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  // Saturating counters: retirements (WB writes) and hazard stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (wb_valid && (retire_cnt != '1)) retire_cnt <= retire_cnt + CNT_W'(1);
      if (hazard   && (stall_cnt  != '1)) stall_cnt  <= stall_cnt  + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;
  localparam int TMAX   = 16;
  localparam int NC     = 400;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       ibus = '0;
  logic              ivalid = 1'b0;
  logic              iready;
  logic              ex_valid, imm_ex, cin_ex;
  logic [2:0]        s_ex;
  logic [ADDR_W-1:0] rs_ex, rt_ex, wb_rd;
  logic [15:0]       imm16_ex;
  logic              wb_valid, illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [CNT_W-1:0]  retire_cnt, stall_cnt;
`endif

  alu_issue_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ibus(ibus), .ivalid(ivalid), .iready(iready),
    .ex_valid(ex_valid), .imm_ex(imm_ex), .s_ex(s_ex), .cin_ex(cin_ex),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .imm16_ex(imm16_ex),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .illegal(illegal)
`ifdef ALU_ISSUE_PERF_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // per-cycle traces of directed runs; index = edges since reset release
  logic       tr_rdy  [TMAX];
  logic       tr_exv  [TMAX];
  logic [4:0] tr_ctl  [TMAX];  // {imm, s, cin}
  logic       tr_wbv  [TMAX];
  logic [4:0] tr_wbrd [TMAX];
  logic       tr_ill  [TMAX];

  // reference model storage for the random run
  logic [31:0] m_ex  [NC+8];
  logic [5:0]  m_wb  [NC+8];
  logic        m_ill [NC+8];

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt,
                                        input int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  // Decode table written straight from the instruction set listing.
  task automatic ref_decode(input logic [31:0] w, output bit lg, output bit im,
                            output logic [2:0] s, output bit ci, output bit urt,
                            output int dst);
    lg = 1; s = 3'b000; ci = 0;
    if (w[31:26] == 6'd0) begin
      im = 0; urt = 1; dst = int'(w[15:11]);
      case (w[5:0])
        6'd3: s = 3'b010;
        6'd2: begin s = 3'b011; ci = 1; end
        6'd1: s = 3'b000;
        6'd7: s = 3'b110;
        6'd4: s = 3'b100;
        default: lg = 0;
      endcase
    end else begin
      im = 1; urt = 0; dst = int'(w[20:16]);
      case (w[31:26])
        6'd3:  s = 3'b010;
        6'd2:  begin s = 3'b011; ci = 1; end
        6'd1:  s = 3'b000;
        6'd15: s = 3'b110;
        6'd12: s = 3'b100;
        default: lg = 0;
      endcase
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one time step after release, before edge 1 ("state 0").
  task automatic do_reset;
    ivalid = 1'b0;
    ibus   = '0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Offers the words with ivalid held and records the outputs of each cycle.
  task automatic run_words(input logic [31:0] w[$], input int ncyc);
    int idx = 0;
    for (int c = 0; c < ncyc; c++) begin
      tr_rdy[c]  = iready;
      tr_exv[c]  = ex_valid;
      tr_ctl[c]  = {imm_ex, s_ex, cin_ex};
      tr_wbv[c]  = wb_valid;
      tr_wbrd[c] = wb_rd;
      tr_ill[c]  = illegal;
      if (idx < w.size()) begin
        ivalid = 1'b1;
        ibus   = w[idx];
        if (iready) idx++;
      end else begin
        ivalid = 1'b0;
        ibus   = '0;
      end
      tick();
    end
    ivalid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({iready, ex_valid, wb_valid, illegal} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state: rdy/exv/wbv/ill=%b expected 1000",
               {iready, ex_valid, wb_valid, illegal});
    end
    checks++;
    if ({imm_ex, s_ex, cin_ex, rs_ex, rt_ex, imm16_ex} !== '0) begin
      errors++;
      $display("FAIL reset_fields: ex fields nonzero");
    end
    // ADD r3,r1,r2 then SUB r4,r3,r1
    ivalid = 1'b1; ibus = enc_r(6'd3, 1, 2, 3);
    tick();
    ibus = enc_r(6'd2, 3, 1, 4);
    tick();
    ivalid = 1'b0; ibus = '0;
    checks++;
    if (iready !== 1'b0) begin
      errors++; $display("FAIL reset_stall_entry: iready=%b expected 0", iready);
    end
    tick();
    checks++;
    if ({iready, ex_valid, wb_valid, wb_rd} !== {3'b001, 5'd3}) begin
      errors++;
      $display("FAIL reset_prestall: rdy/exv/wbv/rd=%b expected 001_00011",
               {iready, ex_valid, wb_valid, wb_rd});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_valid, wb_valid, illegal, iready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_during: exv/wbv/ill/rdy=%b expected 0001",
               {ex_valid, wb_valid, illegal, iready});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (iready !== 1'b1) begin
      errors++; $display("FAIL reset_release_rdy: iready=%b expected 1", iready);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if ({ex_valid, wb_valid} !== 2'b00) begin
        errors++;
        $display("FAIL reset_flush c%0d: exv/wbv=%b expected 00", c, {ex_valid, wb_valid});
      end
    end
  endtask

  task automatic test_independent;
    logic [31:0] q[$];
    logic [4:0]  ectl[3];
    logic [4:0]  erd[3];
    do_reset();
    q = '{enc_i(6'd3, 0, 1, 16'd5), enc_i(6'd12, 0, 2, 16'd3), enc_r(6'd1, 6, 7, 5)};
    ectl = '{5'b1_010_0, 5'b1_100_0, 5'b0_000_0};
    erd  = '{5'd1, 5'd2, 5'd5};
    run_words(q, 8);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (tr_rdy[c] !== 1'b1) begin
        errors++; $display("FAIL indep_rdy c%0d: got %b expected 1", c, tr_rdy[c]);
      end
      checks++;
      if (tr_exv[c] !== (c >= 2 && c <= 4)) begin
        errors++; $display("FAIL indep_exv c%0d: got %b", c, tr_exv[c]);
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (tr_ctl[c] !== ectl[c-2]) begin
          errors++;
          $display("FAIL indep_ctl c%0d: got %b expected %b", c, tr_ctl[c], ectl[c-2]);
        end
      end
      checks++;
      if (tr_wbv[c] !== (c >= 3 && c <= 5)) begin
        errors++; $display("FAIL indep_wbv c%0d: got %b", c, tr_wbv[c]);
      end
      if (c >= 3 && c <= 5) begin
        checks++;
        if (tr_wbrd[c] !== erd[c-3]) begin
          errors++;
          $display("FAIL indep_wbrd c%0d: got %0d expected %0d", c, tr_wbrd[c], erd[c-3]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q[$];
    int zeros = 0;
    do_reset();
    q = '{enc_i(6'd3, 0, 1, 16'd5), enc_r(6'd2, 1, 1, 2)};
    run_words(q, 10);
    for (int c = 0; c < 10; c++) if (tr_rdy[c] === 1'b0) zeros++;
    checks++;
    if (zeros != 2) begin
      errors++; $display("FAIL b2b_stalls: got %0d expected 2", zeros);
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (tr_exv[c] !== (c == 2 || c == 5)) begin
        errors++; $display("FAIL b2b_exv c%0d: got %b", c, tr_exv[c]);
      end
    end
    checks++;
    if (tr_ctl[5] !== 5'b0_011_1) begin
      errors++; $display("FAIL b2b_sub_ctl: got %b expected 00111", tr_ctl[5]);
    end
`ifdef ALU_ISSUE_PERF_EN
    checks++;
    if (retire_cnt !== 16'd2 || stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL perf_counts: retire=%0d stall=%0d expected 2 2", retire_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_distance2;
    logic [31:0] q[$];
    int zeros = 0;
    int wbs = 0;
    do_reset();
    q = '{enc_i(6'd3, 0, 1, 16'd1), enc_i(6'd15, 0, 9, 16'd1), enc_r(6'd3, 1, 0, 3)};
    run_words(q, 12);
    for (int c = 0; c < 12; c++) if (tr_rdy[c] === 1'b0) zeros++;
    checks++;
    if (zeros != 1) begin
      errors++; $display("FAIL dist2_stalls: got %0d expected 1", zeros);
    end
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (tr_exv[c] !== (c == 2 || c == 3 || c == 5)) begin
        errors++; $display("FAIL dist2_exv c%0d: got %b", c, tr_exv[c]);
      end
    end
    do_reset();
    zeros = 0;
    q = '{enc_i(6'd3, 0, 0, 16'd1), enc_r(6'd3, 0, 0, 3)};
    run_words(q, 8);
    for (int c = 0; c < 8; c++) begin
      if (tr_rdy[c] === 1'b0) zeros++;
      if (tr_wbv[c] === 1'b1) wbs++;
    end
    checks++;
    if (zeros != 0) begin
      errors++; $display("FAIL r0_stalls: got %0d expected 0", zeros);
    end
    checks++;
    if (wbs != 2 || tr_wbrd[3] !== 5'd0 || tr_wbrd[4] !== 5'd3) begin
      errors++;
      $display("FAIL r0_wb: count=%0d rd3=%0d rd4=%0d expected 2 0 3", wbs, tr_wbrd[3], tr_wbrd[4]);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] q[$];
    int zeros = 0;
    int wbs = 0;
    int ills = 0;
    do_reset();
    q = '{enc_i(6'd3, 0, 1, 16'd1), 32'hFC00_0000, enc_i(6'd3, 0, 2, 16'd2)};
    run_words(q, 10);
    for (int c = 0; c < 10; c++) begin
      if (tr_rdy[c] === 1'b0) zeros++;
      if (tr_wbv[c] === 1'b1) wbs++;
      if (tr_ill[c] === 1'b1) ills++;
    end
    checks++;
    if (ills != 1 || tr_ill[2] !== 1'b1) begin
      errors++; $display("FAIL ill_pulse: count=%0d at2=%b expected 1 1", ills, tr_ill[2]);
    end
    checks++;
    if (zeros != 0) begin
      errors++; $display("FAIL ill_stalls: got %0d expected 0", zeros);
    end
    checks++;
    if (wbs != 2) begin
      errors++; $display("FAIL ill_wbcount: got %0d expected 2", wbs);
    end
    checks++;
    if (tr_exv[3] !== 1'b0 || tr_exv[4] !== 1'b1) begin
      errors++; $display("FAIL ill_bubble: exv3=%b exv4=%b expected 0 1", tr_exv[3], tr_exv[4]);
    end
  endtask

  // Timing model: a legal word entering ID in cycle n reaches EX in cycle
  // max(n+1, ep+3) over every source produced by a legal word in EX at ep.
  task automatic test_random;
    logic [5:0]  iops[5];
    logic [5:0]  rfn[5];
    int          last_ep[32];
    bit          occ_v = 0;
    int          occ_leave = 0;
    int          n_ret = 0;
    int          n_stall = 0;
    bit          exp_rdy, v, lg, im, ci, urt;
    logic [2:0]  s;
    int          dst, n, e, r, rs, rt;
    logic [31:0] w;
    iops = '{6'd3, 6'd2, 6'd1, 6'd15, 6'd12};
    rfn  = '{6'd3, 6'd2, 6'd1, 6'd7, 6'd4};
    for (int i = 0; i < NC + 8; i++) begin
      m_ex[i] = '0; m_wb[i] = '0; m_ill[i] = 1'b0;
    end
    for (int i = 0; i < 32; i++) last_ep[i] = -100;
    do_reset();
    for (int cyc = 0; cyc < NC; cyc++) begin
      exp_rdy = !occ_v || (cyc + 1 >= occ_leave);
      checks++;
      if (iready !== exp_rdy) begin
        errors++; $display("FAIL rnd_rdy c%0d: got %b expected %b", cyc, iready, exp_rdy);
      end
      checks++;
      if ({ex_valid, imm_ex, s_ex, cin_ex, rs_ex, rt_ex, imm16_ex} !== m_ex[cyc]) begin
        errors++;
        $display("FAIL rnd_ex c%0d: got %h expected %h", cyc,
                 {ex_valid, imm_ex, s_ex, cin_ex, rs_ex, rt_ex, imm16_ex}, m_ex[cyc]);
      end
      checks++;
      if ({wb_valid, wb_rd} !== m_wb[cyc]) begin
        errors++;
        $display("FAIL rnd_wb c%0d: got %b expected %b", cyc, {wb_valid, wb_rd}, m_wb[cyc]);
      end
      checks++;
      if (illegal !== m_ill[cyc]) begin
        errors++; $display("FAIL rnd_ill c%0d: got %b expected %b", cyc, illegal, m_ill[cyc]);
      end
      r  = int'($urandom_range(0, 11));
      rs = int'($urandom_range(0, 3));
      rt = int'($urandom_range(0, 3));
      if (r < 5)       w = enc_i(iops[r], rs, rt, 16'($urandom));
      else if (r < 10) w = enc_r(rfn[r-5], rs, rt, int'($urandom_range(0, 3)));
      else if (r == 10) w = enc_i(6'h3f, rs, rt, 16'($urandom));
      else             w = enc_r(6'h3f, rs, rt, 1);
      v = (cyc < NC - 12) && ($urandom_range(0, 3) != 0);
      ivalid = v;
      ibus   = w;
      if (v && exp_rdy) begin
        n = cyc + 1;
        ref_decode(w, lg, im, s, ci, urt, dst);
        if (lg) begin
          e = n + 1;
          if (rs != 0 && last_ep[rs] + 3 > e) e = last_ep[rs] + 3;
          if (urt && rt != 0 && last_ep[rt] + 3 > e) e = last_ep[rt] + 3;
          m_ex[e]      = {1'b1, im, s, ci, w[25:21], w[20:16], w[15:0]};
          m_wb[e+1]    = {1'b1, 5'(dst)};
          last_ep[dst] = e;
          occ_leave    = e;
          n_ret++;
          n_stall += e - n - 1;
        end else begin
          m_ill[n]  = 1'b1;
          occ_leave = n + 1;
        end
        occ_v = 1;
      end else if (exp_rdy) begin
        occ_v = 0;
      end
      tick();
    end
    ivalid = 1'b0;
`ifdef ALU_ISSUE_PERF_EN
    checks++;
    if (int'(retire_cnt) != n_ret || int'(stall_cnt) != n_stall) begin
      errors++;
      $display("FAIL rnd_perf: retire=%0d stall=%0d expected %0d %0d",
               retire_cnt, stall_cnt, n_ret, n_stall);
    end
`else
    checks++;
    if (n_ret == 0) begin
      errors++; $display("FAIL rnd_activity: no legal instruction retired, expected > 0");
    end
`endif
  endtask

  initial begin
    test_reset();
    test_independent();
    test_back_to_back();
    test_distance2();
    test_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
